uart_frame_arbiter: RTL and testbench

- Shares one byte-level UART transmitter (8N1, handshake tx_dv/tx_active/tx_done) between N_REQ requesters. Each requester supplies a 64-bit result word, such as a ring-oscillator counter snapshot.
- Round-robin arbitration; the granted word is sent as an 11-byte framed packet: header, channel ID, 8 data bytes MSB-first, XOR checksum.
- Sits between the measurement channels and the UART byte transmitter. It replaces per-channel serialisers so the host can demultiplex the streams.

---
 rtl/uart_frame_arbiter_pkg.sv | 18 +
 rtl/uart_frame_arbiter_if.sv | 14 +
 rtl/uart_frame_arbiter_rr_arbiter.sv | 36 +++
 rtl/uart_frame_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_frame_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_arbiter_pkg.sv
// rtl/uart_frame_arbiter_pkg.sv - shared constants and state type for the UART frame arbiter
// Frame layout: byte 0 header, byte 1 channel ID, bytes 2..9 data MSB-first, byte 10 checksum.
package uart_frame_arbiter_pkg;

    localparam int FRAME_LEN = 11;

    localparam logic [3:0] IDX_HDR = 4'd0;
    localparam logic [3:0] IDX_ID  = 4'd1;
    localparam logic [3:0] IDX_CHK = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        GAP
    } state_t;

endpackage

// File: rtl/uart_frame_arbiter_if.sv
// rtl/uart_frame_arbiter_if.sv - byte-level handshake to the shared UART transmitter
// tx_dv     : one-cycle load strobe (arbiter -> transmitter)
// tx_byte   : byte presented with tx_dv, held until the next load
// tx_active : transmitter busy shifting a byte
// tx_done   : one-cycle pulse at the end of each stop bit
interface uart_frame_arbiter_if;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;

    modport master (output tx_dv, output tx_byte, input tx_active, input tx_done);
    modport slave  (input tx_dv, input tx_byte, output tx_active, output tx_done);
endinterface

// File: rtl/uart_frame_arbiter_rr_arbiter.sv
// rtl/uart_frame_arbiter_rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
// req         : request vector
// rr_ptr      : highest-priority channel this round
// grant_oh    : one-hot grant (zero when nothing requests)
// grant_idx   : index of the granted channel
// grant_valid : at least one request present
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] idx;

    // Walk channels in priority order rr_ptr, rr_ptr+1, ... (mod N); first hit wins.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(rr_ptr) + k) % N);
            if (!grant_valid && req[idx]) begin
                grant_valid   = 1'b1;
                grant_idx     = idx;
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_arbiter.sv
// rtl/uart_frame_arbiter.sv - round-robin framer sharing one UART byte transmitter among N_REQ channels
// clk, rst_n : clock, synchronous active-low reset
// req        : per-channel level request, held until ack
// req_data   : channel i word at [64*i+63:64*i]
// ack        : one-cycle pulse, word captured
// busy       : frame in progress (state != IDLE)
// cur_ch     : channel of the frame in progress
// tx         : byte handshake to the transmitter (master side)
module uart_frame_arbiter
    import uart_frame_arbiter_pkg::*;
#(
    parameter int         N_REQ    = 4,
    parameter logic [7:0] HDR_BYTE = 8'hA5,
    parameter int         IFG_CLKS = 87
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [64*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 busy,
    output logic [2:0]           cur_ch,
    uart_frame_arbiter_if.master tx
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t        state, state_nx;
    logic [IW-1:0] rr_ptr, grant_idx;
    logic [N_REQ-1:0] grant_oh;
    logic          grant_valid;
    logic [63:0]   words [N_REQ];
    logic [63:0]   shadow;
    logic [3:0]    byte_idx;
    logic [7:0]    chk, cur_byte;
    logic [2:0]    data_sel;
    logic [15:0]   gap_cnt;
    logic          do_grant, do_load, do_next;

    for (genvar i = 0; i < N_REQ; i++) begin : g_words
        assign words[i] = req_data[64*i +: 64];
    end

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // A new frame or byte is only started with the transmitter idle; this also
    // covers a byte still shifting out after a mid-frame reset.
    always_comb begin
        state_nx = state;
        do_grant = 1'b0;
        do_load  = 1'b0;
        do_next  = 1'b0;
        case (state)
            IDLE: if (grant_valid && !tx.tx_active) begin
                do_grant = 1'b1;
                state_nx = LOAD;
            end
            LOAD: if (!tx.tx_active) begin
                do_load  = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (tx.tx_done) begin
                if (byte_idx == IDX_CHK) begin
                    state_nx = (IFG_CLKS == 0) ? IDLE : GAP;
                end else begin
                    do_next  = 1'b1;
                    state_nx = LOAD;
                end
            end
            GAP: if (gap_cnt == 16'(IFG_CLKS - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Data bytes 2..9 map to shadow bytes 7..0 (MSB first).
    always_comb begin
        data_sel = 3'(4'd9 - byte_idx);
        case (byte_idx)
            IDX_HDR: cur_byte = HDR_BYTE;
            IDX_ID:  cur_byte = {5'b0, cur_ch};
            IDX_CHK: cur_byte = chk;
            default: cur_byte = shadow[{data_sel, 3'b000} +: 8];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack        <= '0;
            tx.tx_dv   <= 1'b0;
            tx.tx_byte <= 8'h00;
            cur_ch     <= 3'd0;
            rr_ptr     <= '0;
            byte_idx   <= 4'd0;
            chk        <= 8'h00;
            gap_cnt    <= 16'd0;
            shadow     <= 64'd0;
        end else begin
            ack      <= '0;
            tx.tx_dv <= 1'b0;
            if (do_grant) begin
                ack      <= grant_oh;
                shadow   <= words[grant_idx];
                cur_ch   <= 3'(grant_idx);
                rr_ptr   <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                byte_idx <= 4'd0;
                chk      <= 8'h00;
            end
            if (do_load) begin
                tx.tx_dv   <= 1'b1;
                tx.tx_byte <= cur_byte;
                // Header is outside the checksum; the checksum byte itself is not folded in.
                if (byte_idx != IDX_HDR && byte_idx != IDX_CHK) chk <= chk ^ cur_byte;
            end
            if (do_next) byte_idx <= byte_idx + 1'b1;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : 16'd0;
        end
    end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// tb/tb_uart_frame_arbiter.sv - self-checking bench for uart_frame_arbiter
module tb_uart_frame_arbiter;

    localparam int N         = 4;
    localparam int IFG       = 12;
    localparam int BYTE_CLKS = 40;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [64*N-1:0] req_data;
    logic [N-1:0] ack;
    logic         busy;
    logic [2:0]   cur_ch;
    logic         force_active;

    uart_frame_arbiter_if ifc ();

    uart_frame_arbiter #(.N_REQ(N), .HDR_BYTE(8'hA5), .IFG_CLKS(IFG)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .busy     (busy),
        .cur_ch   (cur_ch),
        .tx       (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte transmitter model: 4 clocks/bit, 10 bits, one-cycle tx_done after the stop bit.
    int   bit_cnt     = 0;
    logic tx_active_m = 1'b0;
    logic overlap     = 1'b0;
    assign ifc.tx_active = tx_active_m | force_active;

    always @(posedge clk) begin
        ifc.tx_done <= 1'b0;
        if (bit_cnt > 0) begin
            if (ifc.tx_dv) overlap <= 1'b1;
            bit_cnt <= bit_cnt - 1;
            if (bit_cnt == 1) begin
                tx_active_m <= 1'b0;
                ifc.tx_done <= 1'b1;
            end
        end else if (ifc.tx_dv) begin
            if (force_active) overlap <= 1'b1;
            bit_cnt     <= BYTE_CLKS;
            tx_active_m <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_dv_cyc = -1;
    int last_done_cyc = -1;
    int fall_cyc = -1;
    logic prev_busy = 1'b0;
    bit auto_drop = 1'b1;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int ack_q[$];
    int exp_ack[$];

    typedef struct {
        int         ch;
        logic [63:0] word;
        logic [7:0] chk;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ifc.tx_dv) begin
            rx_q.push_back(ifc.tx_byte);
            if (first_dv_cyc < 0) first_dv_cyc = cyc;
        end
        if (ifc.tx_done) last_done_cyc = cyc;
        if (prev_busy && !busy) fall_cyc = cyc;
        prev_busy = busy;
        if (ack != '0) begin
            check("ack_onehot", 64'($onehot(ack)), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    check("ack_only_when_req", 64'(req[i]), 64'd1);
                    ack_q.push_back(i);
                    if (auto_drop) begin
                        req[i] = 1'b0;
                        req_data[64*i +: 64] = {$urandom, $urandom};
                    end
                end
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(req == '0 && !busy && !ifc.tx_active) && n < budget);
        check("done_within_budget", 64'(n < budget), 64'd1);
    endtask

    // Reference frame built straight from the frame definition.
    task automatic push_frame(input int ch, input logic [63:0] w);
        logic [7:0] c, b;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(ch));
        c = 8'(ch);
        for (int k = 7; k >= 0; k--) begin
            b = w[8*k +: 8];
            exp_q.push_back(b);
            c = c ^ b;
        end
        exp_q.push_back(c);
        exp_ack.push_back(ch);
    endtask

    task automatic clear_all();
        rx_q.delete();
        exp_q.delete();
        ack_q.delete();
        exp_ack.delete();
        first_dv_cyc = -1;
    endtask

    task automatic compare_streams(input string tag);
        check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
        check({tag, "_acks"}, 64'(ack_q.size()), 64'(exp_ack.size()));
        for (int i = 0; i < exp_ack.size() && i < ack_q.size(); i++)
            check($sformatf("%s_ack%0d", tag, i), 64'(ack_q[i]), 64'(exp_ack[i]));
    endtask

    task automatic set_word(input int ch, input logic [63:0] w);
        req_data[64*ch +: 64] = w;
    endtask

    initial begin
        int start_cyc;
        int n;
        int model_ptr;
        int last;
        logic [3:0] mask;
        logic [63:0] w;

        tbl[0] = '{2, 64'h0123456789ABCDEF, 8'h02};
        tbl[1] = '{0, 64'h0000000000000000, 8'h00};
        tbl[2] = '{1, 64'h8000000000000001, 8'h80};
        tbl[3] = '{3, 64'hFFFFFFFFFFFFFFFF, 8'h03};

        rst_n = 1'b0;
        req = '0;
        req_data = '0;
        force_active = 1'b0;
        repeat (3) tick();
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_tx_dv", 64'(ifc.tx_dv), 64'd0);
        check("rst_tx_byte", 64'(ifc.tx_byte), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cur_ch", 64'(cur_ch), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single-request frames; auto_drop scrambles the word right after ack.
        for (int v = 0; v < 4; v++) begin
            clear_all();
            push_frame(tbl[v].ch, tbl[v].word);
            set_word(tbl[v].ch, tbl[v].word);
            req[tbl[v].ch] = 1'b1;
            start_cyc = cyc;
            repeat (3) tick();
            check($sformatf("vec%0d_busy", v), 64'(busy), 64'd1);
            check($sformatf("vec%0d_cur_ch", v), 64'(cur_ch), 64'(tbl[v].ch));
            wait_done(800);
            compare_streams($sformatf("vec%0d", v));
            if (rx_q.size() == 11) check($sformatf("vec%0d_chk", v), 64'(rx_q[10]), 64'(tbl[v].chk));
            if (v == 0) begin
                check("latency_req_to_dv", 64'(first_dv_cyc - start_cyc), 64'd2);
                check("ifg_busy_fall", 64'(fall_cyc - last_done_cyc), 64'(IFG + 1));
            end
        end

        // Continuous requests on all channels: strict rotation, pointer starts at 0.
        clear_all();
        auto_drop = 1'b0;
        for (int c = 0; c < N; c++) set_word(c, 64'h1111111111111111 * (c + 1));
        push_frame(0, 64'h1111111111111111);
        push_frame(1, 64'h2222222222222222);
        push_frame(2, 64'h3333333333333333);
        push_frame(3, 64'h4444444444444444);
        push_frame(0, 64'h1111111111111111);
        req = 4'b1111;
        n = 0;
        while (ack_q.size() < 5 && n < 3000) begin
            tick();
            n++;
        end
        req = '0;
        auto_drop = 1'b1;
        wait_done(800);
        compare_streams("rr_all");

        // Pointer wrap: ch1, then 1001 -> ch3 then ch0.
        clear_all();
        set_word(1, 64'hDEADBEEFCAFEF00D);
        push_frame(1, 64'hDEADBEEFCAFEF00D);
        req = 4'b0010;
        wait_done(800);
        set_word(3, 64'h0102030405060708);
        set_word(0, 64'hA0B0C0D0E0F00010);
        push_frame(3, 64'h0102030405060708);
        push_frame(0, 64'hA0B0C0D0E0F00010);
        req = 4'b1001;
        wait_done(1600);
        compare_streams("wrap");

        // Reset during byte 5 with req held.
        clear_all();
        auto_drop = 1'b0;
        set_word(1, 64'h55AA55AA12345678);
        req = 4'b0010;
        n = 0;
        while (rx_q.size() < 6 && n < 2000) begin
            tick();
            n++;
        end
        check("midrst_reached_byte5", 64'(rx_q.size()), 64'd6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_tx_dv", 64'(ifc.tx_dv), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ack", 64'(ack), 64'd0);
        auto_drop = 1'b1;
        push_frame(1, 64'h55AA55AA12345678);
        wait_done(1200);
        check("midrst_len", 64'(rx_q.size()), 64'd17);
        check("midrst_acks", 64'(ack_q.size()), 64'd2);
        for (int i = 0; i < 11 && (i + 6) < rx_q.size(); i++)
            check($sformatf("midrst_byte%0d", i), 64'(rx_q[i+6]), 64'(exp_q[i]));

        // Transmitter busy when the request arrives.
        clear_all();
        force_active = 1'b1;
        set_word(2, 64'hFEDCBA9876543210);
        push_frame(2, 64'hFEDCBA9876543210);
        req = 4'b0100;
        repeat (20) tick();
        check("txbusy_no_ack", 64'(ack_q.size()), 64'd0);
        check("txbusy_no_byte", 64'(rx_q.size()), 64'd0);
        check("txbusy_idle", 64'(busy), 64'd0);
        force_active = 1'b0;
        wait_done(800);
        compare_streams("txbusy");

        // Randomized rounds against a round-robin order model.
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        model_ptr = 0;
        for (int r = 0; r < 6; r++) begin
            clear_all();
            mask = 4'($urandom_range(1, 15));
            last = model_ptr;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (model_ptr + k) % N;
                if (mask[c]) begin
                    w = {$urandom, $urandom};
                    set_word(c, w);
                    push_frame(c, w);
                    last = c;
                end
            end
            model_ptr = (last + 1) % N;
            req = mask;
            wait_done(3000);
            compare_streams($sformatf("rand%0d", r));
        end

        check("no_tx_dv_while_tx_active", 64'(overlap), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
